// File: rtl/digit_serial_mult_ctrl.sv
// Digit-serial unsigned multiplier controller: one shared 4x4 multiplier walks every
// digit pair of a and b and accumulates the shifted partial products into p.
//
// state | meaning
// IDLE  | waiting for start; p holds the last result
// RUN   | issuing digit pair (i, j) to the multiplier, one pair per cycle
// FLUSH | last partial product folded in and result loaded into p
module digit_serial_mult_ctrl #(
  parameter int NDIG = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*NDIG-1:0]   a,
  input  logic [4*NDIG-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [8*NDIG-1:0]   p
);

  localparam int AW = 4 * NDIG;
  localparam int PW = 8 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW = $clog2(PW);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state;
  logic [AW-1:0]   a_q, b_q;
  logic [CW-1:0]   i, j;
  logic [7:0]      prod_q;
  logic [SW-1:0]   shift_q;
  logic            prod_vld;
  logic [PW-1:0]   acc;

  logic [3:0]      dig_a, dig_b;
  logic [7:0]      mult;
  logic [PW-1:0]   addend;
  logic            last_pair;
  logic            last_j;

  assign dig_a     = a_q[4*int'(i) +: 4];
  assign dig_b     = b_q[4*int'(j) +: 4];
  // The only multiplier in the block; every digit pair is time-shared through it.
  assign mult      = 8'(dig_a) * 8'(dig_b);
  assign addend    = PW'(prod_q) << shift_q;
  assign last_j    = (j == CW'(NDIG - 1));
  assign last_pair = last_j && (i == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      i        <= '0;
      j        <= '0;
      prod_q   <= '0;
      shift_q  <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      p        <= '0;
    end else begin
      done     <= 1'b0;
      prod_vld <= 1'b0;
      if (prod_vld) acc <= acc + addend;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          prod_q   <= mult;
          shift_q  <= SW'(4 * (int'(i) + int'(j)));
          prod_vld <= 1'b1;
          if (last_j) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
          if (last_pair) state <= FLUSH;
        end
        FLUSH: begin
          // Last partial product is still in flight; fold it straight into p.
          p     <= acc + addend;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
